line_buf_reader: RTL and testbench

- Read-side controller for the line_buf simple dual-port RAM (11-bit address, 16-bit data, unregistered output, 1-cycle read latency).
- On a start pulse, it reads a line of pixels from a given start address and streams them out on a valid/ready interface with m_last on the final beat.
- Absorbs the RAM read latency and downstream backpressure with a 2-entry skid FIFO, so there are no bubbles while m_ready stays high.
- Sits between line_buf's read port and the downstream video pipeline.

---
 rtl/line_buf_reader_if.sv | 12 +
 rtl/line_buf_reader.sv | 131 +++++++++++++
 tb/tb_line_buf_reader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_reader_if.sv
// Pixel stream channel from the line buffer reader to the downstream video pipeline.
interface line_buf_reader_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/line_buf_reader.sv
// Streams one line from the line_buf RAM, hiding the 1-cycle read latency and
// downstream backpressure behind a 2-entry skid FIFO.
module line_buf_reader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   line_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  line_buf_reader_if.master     strm,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [LEN_W-1:0]        issue_left, issue_left_next;
  logic [LEN_W-1:0]        beat_left, beat_left_next;
  logic                    pending;
  logic                    issue_ok;
  logic                    pop;
  logic                    done_next;
  logic [1:0]              count, count_next;
  logic [DATA_WIDTH-1:0]   head_next, tail, tail_next;

  // Next-state, read issue and skid FIFO update
  always_comb begin
    state_next      = state;
    addr_next       = ram_rd_addr;
    issue_left_next = issue_left;
    beat_left_next  = beat_left;
    done_next       = 1'b0;
    head_next       = strm.m_data;
    tail_next       = tail;

    pop      = strm.m_valid && strm.m_ready;
    // Only issue if the returning word is guaranteed a FIFO slot
    issue_ok = (state == READ) && (issue_left != '0) &&
               ((3'(count) + 3'(pending) - 3'(pop)) < 3'd2);
    count_next = count + 2'(pending) - 2'(pop);

    if (pop) beat_left_next = beat_left - LEN_W'(1);

    case (state)
      IDLE: begin
        if (start) begin
          if (line_len != '0) begin
            addr_next       = start_addr;
            issue_left_next = line_len;
            beat_left_next  = line_len;
            state_next      = READ;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          addr_next       = ram_rd_addr + ADDR_WIDTH'(1);
          issue_left_next = issue_left - LEN_W'(1);
          if (issue_left == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (beat_left == LEN_W'(1))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    case ({pending, pop})
      2'b10: begin
        if (count == 2'd0) head_next = ram_rd_data;
        else               tail_next = ram_rd_data;
      end
      2'b01: begin
        if (count == 2'd2) head_next = tail;
      end
      2'b11: begin
        if (count == 2'd1) begin
          head_next = ram_rd_data;
        end else begin
          head_next = tail;
          tail_next = ram_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state       <= IDLE;
      ram_rd_addr <= '0;
      issue_left  <= '0;
      beat_left   <= '0;
      pending     <= 1'b0;
      count       <= 2'd0;
      tail        <= '0;
      strm.m_data <= '0;
      strm.m_valid <= 1'b0;
      strm.m_last <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      ram_rd_addr <= addr_next;
      issue_left  <= issue_left_next;
      beat_left   <= beat_left_next;
      pending     <= issue_ok;
      count       <= count_next;
      tail        <= tail_next;
      strm.m_data <= head_next;
      strm.m_valid <= (count_next != 2'd0);
      strm.m_last <= (count_next != 2'd0) && (beat_left_next == LEN_W'(1));
      busy        <= (state_next != IDLE);
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_line_buf_reader.sv
// Self-checking bench for line_buf_reader: RAM model holding ~addr, scoreboard
// queue of expected beats, table of line reads plus reset/start corner cases.
module tb_line_buf_reader;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rd_rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   line_len;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          busy, done;

  line_buf_reader_if #(.DATA_WIDTH(DW)) strm ();

  line_buf_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .start(start), .start_addr(start_addr),
    .line_len(line_len), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .strm(strm), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM: data = ~addr, registered read (data valid the cycle after the address)
  always @(posedge clk) ram_rd_data <= ~DW'(ram_rd_addr);

  typedef struct { logic [DW-1:0] d; logic last; } beat_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [AW:0]   len;
    bit            rnd;
    logic [DW-1:0] exp_first;
  } vec_t;

  beat_t q[$];
  int n_pass = 0, n_total = 0;
  int cyc = 0;
  bit mon_en = 0, ready_rnd = 0, prev_stall = 0, busy_seen = 0, valid_seen = 0;
  logic [DW-1:0] prev_data, first_data;
  int beats, done_cnt, done_cyc, first_cyc, last_cyc, first_valid_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Ready driver: constant high, or random with occasional 5-cycle stalls
  initial begin
    int stall = 0;
    strm.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!ready_rnd) strm.m_ready = 1'b1;
      else if (stall > 0) begin strm.m_ready = 1'b0; stall--; end
      else if ($urandom_range(0, 9) == 0) begin strm.m_ready = 1'b0; stall = 4; end
      else strm.m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: scoreboard pop on each accepted beat, stall stability, done/busy tracking
  always @(negedge clk) begin
    if (rd_rst) begin
      prev_stall = 0;
    end else begin
      if (mon_en && strm.m_valid && !valid_seen) begin
        valid_seen = 1; first_valid_cyc = cyc;
      end
      if (mon_en && strm.m_valid && strm.m_ready) begin
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = q.pop_front();
          check("beat_data", 32'(strm.m_data), 32'(e.d));
          check("beat_last", 32'(strm.m_last), 32'(e.last));
        end
        check("fifo_count_le2", 32'(dut.count <= 2'd2), 1);
        beats++;
        if (beats == 1) begin first_cyc = cyc; first_data = strm.m_data; end
        last_cyc = cyc;
      end
      if (mon_en && prev_stall)
        check("stall_stable", {15'd0, strm.m_valid, strm.m_data}, {15'd0, 1'b1, prev_data});
      prev_stall = strm.m_valid && !strm.m_ready;
      prev_data  = strm.m_data;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_seen = 1;
    end
  end

  task automatic clear_stats();
    beats = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
    first_valid_cyc = -1; valid_seen = 0; busy_seen = 0;
  endtask

  task automatic push_line(input logic [AW-1:0] a, input logic [AW:0] len);
    for (int i = 0; i < int'(len); i++) begin
      beat_t b;
      logic [AW-1:0] ad;
      ad = a + AW'(i);
      b.d = ~DW'(ad);
      b.last = (i == int'(len) - 1);
      q.push_back(b);
    end
  endtask

  // Pulse start for one cycle; returns cyc of the cycle before the start edge
  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] len, output int k);
    @(posedge clk); #1;
    k = cyc;
    start = 1'b1; start_addr = a; line_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    check({name, "_done_seen"}, 32'(done_cnt != 0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_line(input vec_t v, input string name);
    int k;
    clear_stats();
    ready_rnd = v.rnd;
    push_line(v.addr, v.len);
    do_start(v.addr, v.len, k);
    @(negedge clk);
    check({name, "_busy_after_start"}, 32'(busy), 32'(v.len != 0));
    wait_done(name, int'(v.len) * 20 + 100);
    check({name, "_done_once"}, 32'(done_cnt), 1);
    check({name, "_beats"}, 32'(beats), 32'(v.len));
    check({name, "_queue_empty"}, 32'(q.size()), 0);
    check({name, "_busy_low"}, 32'(busy), 0);
    check({name, "_valid_low"}, 32'(strm.m_valid), 0);
    if (v.len == 0) begin
      check({name, "_no_busy"}, 32'(busy_seen), 0);
      check({name, "_done_cyc"}, 32'(done_cyc), 32'(k + 1));
    end else begin
      check({name, "_first_data"}, 32'(first_data), 32'(v.exp_first));
      check({name, "_latency"}, 32'(first_valid_cyc), 32'(k + 3));
      check({name, "_done_after_last"}, 32'(done_cyc), 32'(last_cyc + 1));
      if (!v.rnd)
        check({name, "_throughput"}, 32'(last_cyc - first_cyc + 1), 32'(v.len));
    end
    ready_rnd = 0;
    q.delete();
  endtask

  initial begin
    vec_t vecs[5];
    int k;
    vecs[0] = '{addr: 11'h000, len: 12'd16,   rnd: 0, exp_first: 16'hFFFF};
    vecs[1] = '{addr: 11'h7FE, len: 12'd4,    rnd: 0, exp_first: 16'hF801};
    vecs[2] = '{addr: 11'h005, len: 12'd32,   rnd: 1, exp_first: 16'hFFFA};
    vecs[3] = '{addr: 11'h000, len: 12'd0,    rnd: 0, exp_first: 16'h0000};
    vecs[4] = '{addr: 11'h100, len: 12'd2048, rnd: 0, exp_first: 16'hFEFF};

    rd_rst = 1'b1; start = 1'b0; start_addr = '0; line_len = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rd_rst = 1'b0;
    @(negedge clk);
    check("reset_m_valid", 32'(strm.m_valid), 0);
    check("reset_m_last", 32'(strm.m_last), 0);
    check("reset_m_data", 32'(strm.m_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_rd_addr", 32'(ram_rd_addr), 0);
    mon_en = 1;

    for (int i = 0; i < 5; i++) run_line(vecs[i], $sformatf("vec%0d", i));

    // start during READ must be ignored
    clear_stats();
    push_line(11'h010, 12'd8);
    do_start(11'h010, 12'd8, k);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 11'h200; line_len = 12'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", 300);
    check("ign_beats", 32'(beats), 8);
    check("ign_done_once", 32'(done_cnt), 1);
    check("ign_queue_empty", 32'(q.size()), 0);
    q.delete();

    // reset mid-line at beat 7 of 20
    clear_stats();
    push_line(11'h040, 12'd20);
    do_start(11'h040, 12'd20, k);
    for (int i = 0; i < 200 && beats < 7; i++) @(negedge clk);
    check("rst_reached_beat7", 32'(beats), 7);
    @(posedge clk); #1;
    mon_en = 0; rd_rst = 1'b1;
    @(posedge clk); #1;
    rd_rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", 32'(strm.m_valid), 0);
    check("midrst_m_last", 32'(strm.m_last), 0);
    check("midrst_m_data", 32'(strm.m_data), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_rd_addr", 32'(ram_rd_addr), 0);
    q.delete();
    clear_stats();
    mon_en = 1;
    repeat (10) @(negedge clk);
    check("midrst_no_beats", 32'(beats), 0);
    check("midrst_no_done", 32'(done_cnt), 0);
    begin
      vec_t v;
      v = '{addr: 11'h300, len: 12'd3, rnd: 0, exp_first: 16'hFCFF};
      run_line(v, "post_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
